alu_serial_rx: RTL and testbench
================================

ALU_SERIAL_RX -- requirements
Module: alu_serial_rx

Interface
REQ-001 Parameters: none; the frame format and CRC are fixed.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  in  1  reset: synchronous, active-low.
REQ-004 sin  in  1  serial input; idle level 1; changes at negedge clk and is sampled at posedge clk.
REQ-005 cmd_valid  out  1  one-cycle pulse: a command frame has completed.
REQ-006 cmd_A  out  32  operand A of the last completed frame.
REQ-007 cmd_B  out  32  operand B of the last completed frame.
REQ-008 cmd_op  out  3  op field of the last completed frame.
REQ-009 err_data  out  1  last frame did not contain exactly 8 DATA packets.
REQ-010 err_crc  out  1  last frame had a CRC mismatch.
REQ-011 err_op  out  1  last frame had an unsupported op code.

Function
REQ-012 The packet format SHALL be 11 bits at 1 bit/clk: start 0, type (0=DATA, 1=CTL), 8 payload bits MSB first, stop 1.
REQ-013 The packet FSM SHALL use states WAIT_HIGH -> IDLE -> TYPE -> BITS (8 cycles, counter 0..7) -> STOP -> IDLE.
REQ-014 In IDLE, the FSM SHALL move to TYPE when sin is sampled 0; otherwise it SHALL stay in IDLE.
REQ-015 In STOP, if sin is sampled 0 (framing error), the packet SHALL be discarded, the byte count and partial frame SHALL be cleared, the FSM SHALL go to WAIT_HIGH, and no outputs SHALL change.
REQ-016 WAIT_HIGH SHALL move to IDLE once sin is sampled 1.
REQ-017 Each DATA packet SHALL shift its byte into a 64-bit frame register: bytes 1-4 form B[31:24]..B[7:0], bytes 5-8 form A[31:24]..A[7:0].
REQ-018 A 4-bit DATA count SHALL saturate at 9; a 9th or later DATA packet SHALL be ignored but SHALL mark the frame as overlong.
REQ-019 A CTL packet SHALL end the frame; its payload is {1'b0, op[2:0], crc[3:0]}.
REQ-020 The CRC SHALL use polynomial x^4+x+1 with initial value 0000 over d[67:0] = {B, A, 1'b1, op}, where d[67] is the first bit in.
REQ-021 The frame checks SHALL be applied in priority order, and only one error flag SHALL be set per frame:
- DATA count != 8 -> err_data=1;
- else received crc != computed CRC -> err_crc=1;
- else op not in {000 AND, 001 OR, 100 ADD, 101 SUB} -> err_op=1;
- else no flag set.
REQ-022 Latency: cmd_valid SHALL go high on the posedge after the posedge that samples the CTL stop bit, for exactly 1 cycle.
REQ-023 cmd_A, cmd_B, cmd_op and the error flags SHALL update on that same edge and hold until the next cmd_valid.
REQ-024 cmd_A/cmd_B SHALL carry the received (possibly partial) values even when a flag is set.
REQ-025 After each CTL packet, the DATA count and frame register SHALL clear regardless of the outcome.
REQ-026 A start bit SHALL be accepted in the same cycle cmd_valid is high; back-to-back frames SHALL need no idle gap beyond the stop bit.
REQ-027 A CTL packet whose framing fails SHALL NOT produce cmd_valid.

Reset
REQ-028 When rst_n is 0 at posedge, then on that edge:
- all outputs SHALL be 0;
- the FSM SHALL go to WAIT_HIGH;
- the DATA count, bit counter and frame register SHALL clear.
REQ-029 Reset in the middle of a packet or frame SHALL abort it with no cmd_valid; the next frame SHALL be received normally after sin is sampled 1.

Verification
REQ-030 A=0, B=0, 8 DATA bytes 0x00, then CTL 0x0B (op AND, CRC 1011) -> one cmd_valid pulse, cmd_op=000, all error flags 0.
REQ-031 Same frame with CTL 0x0A -> cmd_valid with err_crc=1 only.
REQ-032 Only 2 DATA packets, then CTL with any CRC -> cmd_valid with err_data=1, err_crc=0; the next correct frame -> no error.
REQ-033 Valid-CRC frame with op 010 -> cmd_valid with err_op=1; ops 000/001/100/101 with correct CRC -> no flag.
REQ-034 rst_n=0 for 1 cycle during the 5th DATA byte, then a full valid frame -> exactly one cmd_valid, with A/B equal to the second frame's values.
REQ-035 Stop bit forced to 0 on byte 3, sin returned to 1, then a full frame -> exactly one cmd_valid, no error flags.

Source files
------------

// File: rtl/alu_serial_rx.sv
// alu_serial_rx: receives 11-bit serial packets, assembles DATA bytes into a
// 64-bit {B, A} frame and, on a CTL packet, checks the frame and presents the
// command.
// Results appear one cycle after the CTL stop bit, together with a
// one-cycle cmd_valid pulse.
module alu_serial_rx (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sin,
    output logic        cmd_valid,
    output logic [31:0] cmd_A,
    output logic [31:0] cmd_B,
    output logic [2:0]  cmd_op,
    output logic        err_data,
    output logic        err_crc,
    output logic        err_op
);

    typedef enum logic [2:0] {
        WAIT_HIGH,
        IDLE,
        TYPE,
        BITS,
        STOP
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        type_q, type_d;
    logic [7:0]  shift_q, shift_d;
    logic [63:0] frame_q, frame_d;
    logic [3:0]  dcnt_q, dcnt_d;
    logic        pend_q, pend_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [31:0] cmd_a_q, cmd_a_d;
    logic [31:0] cmd_b_q, cmd_b_d;
    logic [2:0]  cmd_op_q, cmd_op_d;
    logic        err_data_q, err_data_d;
    logic        err_crc_q, err_crc_d;
    logic        err_op_q, err_op_d;
    logic [3:0]  crc_calc;

    // Serial CRC x^4+x+1, initial value 0, d[67] shifted in first.
    function automatic logic [3:0] crc4(input logic [67:0] d);
        logic [3:0] c;
        logic       fb;
        c = 4'b0000;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ d[i];
            c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
        end
        return c;
    endfunction

    // Op codes this ALU supports: AND, OR, ADD, SUB.
    function automatic logic op_supported(input logic [2:0] op);
        return (op == 3'b000) || (op == 3'b001) ||
               (op == 3'b100) || (op == 3'b101);
    endfunction

    // CRC over the assembled frame, the constant 1 and the op of the CTL payload
    always_comb begin
        crc_calc = crc4({frame_q, 1'b1, shift_q[6:4]});
    end

    // Next-state logic: packet FSM, frame assembly and deferred frame evaluation
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        type_d      = type_q;
        shift_d     = shift_q;
        frame_d     = frame_q;
        dcnt_d      = dcnt_q;
        pend_d      = 1'b0;
        cmd_valid_d = 1'b0;
        cmd_a_d     = cmd_a_q;
        cmd_b_d     = cmd_b_q;
        cmd_op_d    = cmd_op_q;
        err_data_d  = err_data_q;
        err_crc_d   = err_crc_q;
        err_op_d    = err_op_q;

        // The CTL payload and the frame stay untouched for the cycle after the
        // stop bit (the next packet cannot reach BITS that soon), so the
        // evaluation and the frame clear happen here, one cycle later.
        if (pend_q) begin
            cmd_valid_d = 1'b1;
            cmd_a_d     = frame_q[31:0];
            cmd_b_d     = frame_q[63:32];
            cmd_op_d    = shift_q[6:4];
            err_data_d  = 1'b0;
            err_crc_d   = 1'b0;
            err_op_d    = 1'b0;
            if (dcnt_q != 4'd8) begin
                err_data_d = 1'b1;
            end else if (shift_q[3:0] != crc_calc) begin
                err_crc_d = 1'b1;
            end else if (!op_supported(shift_q[6:4])) begin
                err_op_d = 1'b1;
            end
            frame_d = 64'd0;
            dcnt_d  = 4'd0;
        end

        case (state_q)
            WAIT_HIGH: begin
                if (sin) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (!sin) begin
                    state_d = TYPE;
                end
            end
            TYPE: begin
                type_d    = sin;
                bit_cnt_d = 3'd0;
                state_d   = BITS;
            end
            BITS: begin
                shift_d = {shift_q[6:0], sin};
                if (bit_cnt_q == 3'd7) begin
                    state_d = STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            STOP: begin
                if (!sin) begin
                    // Framing error: drop the packet and whatever frame was in progress.
                    frame_d = 64'd0;
                    dcnt_d  = 4'd0;
                    state_d = WAIT_HIGH;
                end else begin
                    state_d = IDLE;
                    if (type_q) begin
                        pend_d = 1'b1;
                    end else if (dcnt_q < 4'd9) begin
                        dcnt_d = dcnt_q + 4'd1;
                        // Bytes beyond the eighth only mark the frame overlong.
                        if (dcnt_q < 4'd8) begin
                            frame_d = {frame_q[55:0], shift_q};
                        end
                    end
                end
            end
            default: begin
                state_d = WAIT_HIGH;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= WAIT_HIGH;
            bit_cnt_q   <= 3'd0;
            type_q      <= 1'b0;
            shift_q     <= 8'd0;
            frame_q     <= 64'd0;
            dcnt_q      <= 4'd0;
            pend_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_a_q     <= 32'd0;
            cmd_b_q     <= 32'd0;
            cmd_op_q    <= 3'd0;
            err_data_q  <= 1'b0;
            err_crc_q   <= 1'b0;
            err_op_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            type_q      <= type_d;
            shift_q     <= shift_d;
            frame_q     <= frame_d;
            dcnt_q      <= dcnt_d;
            pend_q      <= pend_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_a_q     <= cmd_a_d;
            cmd_b_q     <= cmd_b_d;
            cmd_op_q    <= cmd_op_d;
            err_data_q  <= err_data_d;
            err_crc_q   <= err_crc_d;
            err_op_q    <= err_op_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_A     = cmd_a_q;
    assign cmd_B     = cmd_b_q;
    assign cmd_op    = cmd_op_q;
    assign err_data  = err_data_q;
    assign err_crc   = err_crc_q;
    assign err_op    = err_op_q;

endmodule

// File: tb/tb_alu_serial_rx.sv
// Testbench for alu_serial_rx: drives serial packets and compares every
// cmd_valid pulse (timing and contents) and the held outputs against a
// frame-level reference model.
module tb_alu_serial_rx;

    logic        clk;
    logic        rst_n;
    logic        sin;
    logic        cmd_valid;
    logic [31:0] cmd_A;
    logic [31:0] cmd_B;
    logic [2:0]  cmd_op;
    logic        err_data;
    logic        err_crc;
    logic        err_op;

    alu_serial_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sin       (sin),
        .cmd_valid (cmd_valid),
        .cmd_A     (cmd_A),
        .cmd_B     (cmd_B),
        .cmd_op    (cmd_op),
        .err_data  (err_data),
        .err_crc   (err_crc),
        .err_op    (err_op)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        ed;
        logic        ec;
        logic        eo;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  mbytes[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    logic [69:0] last_out = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference CRC: remainder of d(x)*x^4 divided by x^4+x+1.
    function automatic logic [3:0] ref_crc(input logic [67:0] d);
        logic [71:0] v;
        v = {d, 4'b0000};
        for (int i = 71; i >= 4; i--) begin
            if (v[i]) v[i -: 5] = v[i -: 5] ^ 5'b10011;
        end
        return v[3:0];
    endfunction

    // Frame register as the model sees it: the first eight bytes, first byte on top.
    function automatic logic [63:0] model_frame();
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < mbytes.size() && i < 8; i++) v = {v[55:0], mbytes[i]};
        return v;
    endfunction

    function automatic logic [7:0] good_ctl(input logic [2:0] op);
        return {1'b0, op, ref_crc({model_frame(), 1'b1, op})};
    endfunction

    task automatic drive(input logic b);
        @(negedge clk);
        sin = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1);
    endtask

    task automatic send_pkt(input logic typ, input logic [7:0] payload, input logic stop_ok);
        exp_t        e;
        logic [63:0] f;
        drive(1'b0);
        drive(typ);
        for (int i = 7; i >= 0; i--) drive(payload[i]);
        drive(stop_ok);
        if (!stop_ok) begin
            mbytes.delete();
        end else if (!typ) begin
            mbytes.push_back(payload);
        end else begin
            f    = model_frame();
            e.a  = f[31:0];
            e.b  = f[63:32];
            e.op = payload[6:4];
            e.ed = (mbytes.size() != 8);
            e.ec = !e.ed && (payload[3:0] != ref_crc({f, 1'b1, payload[6:4]}));
            e.eo = !e.ed && !e.ec &&
                   !(payload[6:4] inside {3'b000, 3'b001, 3'b100, 3'b101});
            e.cyc = cyc + 2;
            exp_q.push_back(e);
            mbytes.delete();
        end
    endtask

    task automatic send_data(input logic [31:0] a, input logic [31:0] b);
        for (int i = 3; i >= 0; i--) send_pkt(1'b0, b[8*i +: 8], 1'b1);
        for (int i = 3; i >= 0; i--) send_pkt(1'b0, a[8*i +: 8], 1'b1);
    endtask

    task automatic send_frame(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        send_data(a, b);
        send_pkt(1'b1, good_ctl(op), 1'b1);
    endtask

    // Output monitor: pulses must match the expectation queue, outputs must hold otherwise.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst_n) begin
            check("reset_outputs", {cmd_valid, cmd_A, cmd_B, cmd_op, err_data, err_crc, err_op}, '0);
            last_out = '0;
        end else if (cmd_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("latency", cyc, e.cyc);
                check("cmd_A", cmd_A, e.a);
                check("cmd_B", cmd_B, e.b);
                check("cmd_op", cmd_op, e.op);
                check("flags", {err_data, err_crc, err_op}, {e.ed, e.ec, e.eo});
            end
            last_out = {cmd_A, cmd_B, cmd_op, err_data, err_crc, err_op};
        end else begin
            check("hold", {cmd_A, cmd_B, cmd_op, err_data, err_crc, err_op}, last_out);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  rop;
        logic [7:0]  ctl;
        int          n, r;
        logic [2:0]  ops[4];
        ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b100; ops[3] = 3'b101;

        sin   = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        // All-zero frame with a good and a bad CRC
        send_data(32'h0, 32'h0);
        send_pkt(1'b1, 8'h0B, 1'b1);
        idle(2);
        send_data(32'h0, 32'h0);
        send_pkt(1'b1, 8'h0A, 1'b1);
        idle(2);

        // Short frame, then a correct one back-to-back
        send_pkt(1'b0, 8'h5A, 1'b1);
        send_pkt(1'b0, 8'hC3, 1'b1);
        send_pkt(1'b1, 8'h07, 1'b1);
        send_frame(32'h1234_5678, 32'h9ABC_DEF0, 3'b100);
        idle(1);

        // Unsupported op, then every supported op
        send_frame(32'hDEAD_BEEF, 32'h0BAD_F00D, 3'b010);
        for (int i = 0; i < 4; i++) send_frame($urandom, $urandom, ops[i]);
        idle(2);

        // Reset in the middle of the fifth DATA byte
        send_pkt(1'b0, 8'h11, 1'b1);
        send_pkt(1'b0, 8'h22, 1'b1);
        send_pkt(1'b0, 8'h33, 1'b1);
        send_pkt(1'b0, 8'h44, 1'b1);
        drive(1'b0);
        drive(1'b0);
        drive(1'b1);
        drive(1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        sin   = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        mbytes.delete();
        idle(1);
        send_frame(32'hA5A5_0F0F, 32'h3C3C_F0F0, 3'b001);
        idle(2);

        // Framing error on the third byte
        send_pkt(1'b0, 8'hAA, 1'b1);
        send_pkt(1'b0, 8'hBB, 1'b1);
        send_pkt(1'b0, 8'hCC, 1'b0);
        idle(2);
        send_frame(32'h0102_0304, 32'h0506_0708, 3'b101);
        idle(2);

        // Randomized frames: byte counts, ops, CRC corruption and inter-frame gaps
        for (int k = 0; k < 40; k++) begin
            r   = $urandom_range(0, 9);
            n   = (r < 6) ? 8 : (r == 6) ? $urandom_range(0, 7) : (r == 7) ? 9 : 10;
            rop = 3'($urandom_range(0, 7));
            for (int i = 0; i < n; i++) send_pkt(1'b0, 8'($urandom), 1'b1);
            ctl = good_ctl(rop);
            if ($urandom_range(0, 3) == 0) ctl[3:0] = ctl[3:0] ^ 4'($urandom_range(1, 15));
            send_pkt(1'b1, ctl, 1'b1);
            idle($urandom_range(0, 3));
        end

        idle(5);
        check("missing_valid", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
